// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the writeback register file (regfile_wb).
// Optional same-cycle read bypass is enabled by defining REGFILE_WB_BYPASS_EN.
package regfile_wb_pkg;

  localparam int NREG = 64;
  localparam int AW   = 6;
  localparam int DW   = 32;

  localparam logic [AW-1:0] ZERO_REG = '0;

  // Number of writeback ports; index order is ascending priority (alu, mem, io).
  localparam int NWB = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
  } wb_port_t;

  // True when a writeback port carries a real write that targets addr.
  function automatic logic wb_hit(input logic [AW-1:0] port_addr,
                                  input logic [AW-1:0] addr);
    return (port_addr != ZERO_REG) && (port_addr == addr);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard for regfile_wb: issue sets, writeback clears,
// set wins on a same-cycle collision, register 0 is never pending.
// With REGFILE_WB_BYPASS_EN a register being written back this cycle reads not busy.
module regfile_scoreboard
  import regfile_wb_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_dd,
  input  logic [AW-1:0] alu_addr,
  input  logic [AW-1:0] mem_addr,
  input  logic [AW-1:0] io_addr,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic          rs_busy,
  output logic          rt_busy
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Next pending vector: clears first, then the issue set so the younger producer wins.
  always_comb begin
    pending_nxt = pending;
    if (alu_addr != ZERO_REG) pending_nxt[alu_addr] = 1'b0;
    if (mem_addr != ZERO_REG) pending_nxt[mem_addr] = 1'b0;
    if (io_addr  != ZERO_REG) pending_nxt[io_addr]  = 1'b0;
    if (iss_en && (iss_dd != ZERO_REG)) pending_nxt[iss_dd] = 1'b1;
    pending_nxt[ZERO_REG] = 1'b0;
  end

  // Pending register; reset discards all in-flight producers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Busy lookups for both read ports.
  always_comb begin
    rs_busy = pending[rs_addr];
    rt_busy = pending[rt_addr];
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_hit(alu_addr, rs_addr) || wb_hit(mem_addr, rs_addr) || wb_hit(io_addr, rs_addr))
      rs_busy = 1'b0;
    if (wb_hit(alu_addr, rt_addr) || wb_hit(mem_addr, rt_addr) || wb_hit(io_addr, rt_addr))
      rt_busy = 1'b0;
`endif
  end

endmodule

// File: rtl/regfile_wb.sv
// Writeback-side register file: 64 x 32-bit registers written by the ALU, MEM
// and IO result buses (io > mem > alu on a shared target), two combinational
// read ports, a pending scoreboard and a sticky writeback-conflict flag.
// Define REGFILE_WB_BYPASS_EN to forward same-cycle writebacks to the read ports.
module regfile_wb
  import regfile_wb_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_val,
  output logic [DW-1:0] rt_val,
  output logic          rs_busy,
  output logic          rt_busy,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_dd,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_dd_val,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_dd_val,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_dd_val,
  output logic          wb_conflict
);

  wb_port_t        wb [NWB];
  logic [DW-1:0]   regs [NREG];
  logic            conflict_now;

  assign wb[0] = '{addr: alu_addr, val: alu_dd_val};
  assign wb[1] = '{addr: mem_addr, val: mem_dd_val};
  assign wb[2] = '{addr: io_addr,  val: io_dd_val};

  // Register array write; later ports in the loop override earlier ones, giving io > mem > alu.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NWB; p++) begin
        if (wb[p].addr != ZERO_REG) regs[wb[p].addr] <= wb[p].val;
      end
    end
  end

  // Combinational operand reads, optionally forwarding same-cycle writebacks.
  always_comb begin
    rs_val = regs[rs_addr];
    rt_val = regs[rt_addr];
`ifdef REGFILE_WB_BYPASS_EN
    for (int p = 0; p < NWB; p++) begin
      if (wb_hit(wb[p].addr, rs_addr)) rs_val = wb[p].val;
      if (wb_hit(wb[p].addr, rt_addr)) rt_val = wb[p].val;
    end
`endif
    if (rs_addr == ZERO_REG) rs_val = '0;
    if (rt_addr == ZERO_REG) rt_val = '0;
  end

  // Any two ports aimed at the same nonzero register this cycle.
  always_comb begin
    conflict_now = wb_hit(alu_addr, mem_addr) ||
                   wb_hit(alu_addr, io_addr)  ||
                   wb_hit(mem_addr, io_addr);
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_conflict <= 1'b0;
    end else if (conflict_now) begin
      wb_conflict <= 1'b1;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .iss_en   (iss_en),
    .iss_dd   (iss_dd),
    .alu_addr (alu_addr),
    .mem_addr (mem_addr),
    .io_addr  (io_addr),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy)
  );

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb with a queue of expected values.
module tb_regfile_wb;
  import regfile_wb_pkg::*;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] rs_addr, rt_addr, iss_dd, alu_addr, mem_addr, io_addr;
  logic [DW-1:0] rs_val, rt_val, alu_dd_val, mem_dd_val, io_dd_val;
  logic          rs_busy, rt_busy, iss_en, wb_conflict;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  regfile_wb dut (
    .clk        (clk),
    .rstn       (rstn),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .rs_busy    (rs_busy),
    .rt_busy    (rt_busy),
    .iss_en     (iss_en),
    .iss_dd     (iss_dd),
    .alu_addr   (alu_addr),
    .alu_dd_val (alu_dd_val),
    .mem_addr   (mem_addr),
    .mem_dd_val (mem_dd_val),
    .io_addr    (io_addr),
    .io_dd_val  (io_dd_val),
    .wb_conflict(wb_conflict)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_fails++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle_inputs();
    iss_en = 1'b0; iss_dd = '0;
    alu_addr = '0; alu_dd_val = '0;
    mem_addr = '0; mem_dd_val = '0;
    io_addr  = '0; io_dd_val  = '0;
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    rs_addr = 6'd5;
    rt_addr = 6'd9;
    idle_inputs();
    #1;
    expect_val("reset_rs_val", 32'h0);      check(rs_val);
    expect_val("reset_rt_val", 32'h0);      check(rt_val);
    expect_val("reset_rs_busy", 32'h0);     check({31'b0, rs_busy});
    expect_val("reset_conflict", 32'h0);    check({31'b0, wb_conflict});
    #2 rstn = 1'b1;

    // Basic ALU write, read back next cycle.
    alu_addr = 6'd5; alu_dd_val = 32'h12345678;
    expect_val("alu_write_val", 32'h12345678);
    expect_val("alu_write_busy", 32'h0);
    step(); idle_inputs(); rs_addr = 6'd5; #1;
    check(rs_val);
    check({31'b0, rs_busy});

    // Register 0 protection on write and issue.
    io_addr = 6'd0; io_dd_val = 32'hFFFFFFFF; iss_en = 1'b1; iss_dd = 6'd0;
    expect_val("r0_val", 32'h0);
    expect_val("r0_busy", 32'h0);
    expect_val("r0_no_conflict", 32'h0);
    step(); idle_inputs(); rs_addr = 6'd0; #1;
    check(rs_val);
    check({31'b0, rs_busy});
    check({31'b0, wb_conflict});

    // Three-way collision on register 9: io wins, conflict sets and sticks.
    alu_addr = 6'd9; alu_dd_val = 32'd1;
    mem_addr = 6'd9; mem_dd_val = 32'd2;
    io_addr  = 6'd9; io_dd_val  = 32'd3;
    expect_val("collide_val", 32'd3);
    expect_val("collide_flag", 32'h1);
    step(); idle_inputs(); rs_addr = 6'd9; #1;
    check(rs_val);
    check({31'b0, wb_conflict});
    expect_val("conflict_sticky", 32'h1);
    step(); step(); check({31'b0, wb_conflict});

    // Scoreboard set then clear on register 12.
    iss_en = 1'b1; iss_dd = 6'd12;
    expect_val("sb_set_busy", 32'h1);
    step(); idle_inputs(); rt_addr = 6'd12; #1;
    check({31'b0, rt_busy});
    expect_val("sb_hold_busy", 32'h1);
    step(); step(); check({31'b0, rt_busy});
    mem_addr = 6'd12; mem_dd_val = 32'hAB; #1;
`ifdef REGFILE_WB_BYPASS_EN
    expect_val("sb_wb_cycle_busy", 32'h0);
    expect_val("sb_wb_cycle_val", 32'hAB);
`else
    expect_val("sb_wb_cycle_busy", 32'h1);
    expect_val("sb_wb_cycle_val", 32'h0);
`endif
    check({31'b0, rt_busy});
    check(rt_val);
    expect_val("sb_clear_busy", 32'h0);
    expect_val("sb_clear_val", 32'hAB);
    step(); idle_inputs(); #1;
    check({31'b0, rt_busy});
    check(rt_val);

    // Set-wins race on register 7.
    iss_en = 1'b1; iss_dd = 6'd7;
    step(); idle_inputs(); rs_addr = 6'd7;
    alu_addr = 6'd7; alu_dd_val = 32'h77; iss_en = 1'b1; iss_dd = 6'd7;
    expect_val("race_val", 32'h77);
    expect_val("race_busy", 32'h1);
    step(); idle_inputs(); #1;
    check(rs_val);
    check({31'b0, rs_busy});
    alu_addr = 6'd7; alu_dd_val = 32'h78;
    expect_val("race_later_clear", 32'h0);
    step(); idle_inputs(); #1;
    check({31'b0, rs_busy});

    // Bypass on register 20 and priority on register 21.
    io_addr = 6'd20; io_dd_val = 32'h11;
    step(); idle_inputs();
    io_addr = 6'd20; io_dd_val = 32'h55; rs_addr = 6'd20;
    mem_addr = 6'd21; mem_dd_val = 32'hA; alu_addr = 6'd21; alu_dd_val = 32'hB; rt_addr = 6'd21;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    expect_val("bypass_rs", 32'h55);
    expect_val("bypass_prio_rt", 32'hA);
`else
    expect_val("bypass_rs", 32'h11);
    expect_val("bypass_prio_rt", 32'h0);
`endif
    check(rs_val);
    check(rt_val);
    expect_val("after_bypass_rs", 32'h55);
    expect_val("after_prio_rt", 32'hA);
    step(); idle_inputs(); #1;
    check(rs_val);
    check(rt_val);

    // Mid-operation asynchronous reset.
    iss_en = 1'b1; iss_dd = 6'd30;
    step(); idle_inputs(); rs_addr = 6'd30; rt_addr = 6'd9; #1;
    expect_val("pre_rst_busy", 32'h1);   check({31'b0, rs_busy});
    expect_val("pre_rst_rt_val", 32'd3); check(rt_val);
    #1 rstn = 1'b0; #1;
    expect_val("mid_rst_busy", 32'h0);     check({31'b0, rs_busy});
    expect_val("mid_rst_rt_val", 32'h0);   check(rt_val);
    expect_val("mid_rst_conflict", 32'h0); check({31'b0, wb_conflict});
    #1 rstn = 1'b1;
    step();
    alu_addr = 6'd30; alu_dd_val = 32'h30;
    expect_val("post_rst_val", 32'h30);
    expect_val("post_rst_busy", 32'h0);
    step(); idle_inputs(); #1;
    check(rs_val);
    check({31'b0, rs_busy});

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL leftover_expectations: observed %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
